// File: rtl/router_pkg.sv
// Shared definitions for the router output FIFOs.
// Holds the default FIFO geometry, the header byte field slices
// (length in [7:2], destination address in [1:0]), the address value
// that no destination answers to, and a helper to pull the length field.
package router_pkg;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  // Header byte layout
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Payload length carried in a header byte
  function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-destination output FIFO of the 1-to-3 packet router.
// Stores {header_flag, byte} words, tracks the length of the packet being
// read out, and blanks data_out to zero between packets.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   soft_reset  synchronous flush (timeout); same effect as reset
//   write_enb   write strobe
//   read_enb    read strobe
//   lfd_state   header flag stored alongside data_in
//   data_in     byte to write
//   data_out    registered read data (1-cycle latency)
//   full        DEPTH entries held
//   empty       no entries held
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = router_pkg::DEPTH,
  parameter int WIDTH = router_pkg::WIDTH,
  parameter int AW    = router_pkg::AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH:0]   mem_q [DEPTH];

  logic             clr;
  logic             do_wr, do_rd;
  logic [WIDTH:0]   rd_word;

  assign clr     = reset | soft_reset;

  // Extra pointer MSB distinguishes full from empty when the indexes match
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Both strobes qualified by the pre-edge flags
  assign do_wr   = write_enb & ~full;
  assign do_rd   = read_enb & ~empty;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rd_word[WIDTH-1:0];
      // Header reload counts payload plus the trailing parity byte
      if (rd_word[WIDTH])
        pkt_cnt_d = {1'b0, hdr_len(rd_word[7:0])} + 7'd1;
      else if (pkt_cnt_q != 7'd0)
        pkt_cnt_d = pkt_cnt_q - 7'd1;
    end else if (pkt_cnt_q == 7'd0) begin
      // Idle between packets: present zero to the destination
      data_out_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is not cleared by reset; pointers alone define validity
  always_ff @(posedge clock) begin
    if (!clr && do_wr) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed steps followed by random
// traffic, all compared against a queue-based reference model.
module tb_router_fifo;

  localparam int DEPTH = router_pkg::DEPTH;

  logic       clock = 1'b0;
  logic       reset, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [8:0] m_q [$];
  int         m_pkt  = 0;
  logic [7:0] m_dout = 8'h00;

  router_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic model_step(input logic rst, srst, we, re, lfd, input logic [7:0] din);
    bit m_full, m_empty;
    logic [8:0] w;
    if (rst || srst) begin
      m_q.delete();
      m_pkt  = 0;
      m_dout = 8'h00;
      return;
    end
    m_full  = (m_q.size() == DEPTH);
    m_empty = (m_q.size() == 0);
    if (re && !m_empty) begin
      w      = m_q.pop_front();
      m_dout = w[7:0];
      if (w[8])          m_pkt = int'(w[7:2]) + 1;
      else if (m_pkt > 0) m_pkt = m_pkt - 1;
    end else if (m_pkt == 0) begin
      m_dout = 8'h00;
    end
    if (we && !m_full) m_q.push_back({lfd, din});
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance model, sample 1ns after the edge
  task automatic cyc(input string tag, input logic rst, srst, we, re, lfd,
                     input logic [7:0] din);
    reset = rst; soft_reset = srst; write_enb = we; read_enb = re;
    lfd_state = lfd; data_in = din;
    @(posedge clock);
    model_step(rst, srst, we, re, lfd, din);
    #1;
    chk8({tag, ".dout"},  data_out, m_dout);
    chk1({tag, ".full"},  full,  m_q.size() == DEPTH);
    chk1({tag, ".empty"}, empty, m_q.size() == 0);
  endtask

  initial begin
    logic [7:0] pkt [5];
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;

    // Reset and idle
    cyc("rst", 1, 0, 0, 0, 0, 8'h00);
    cyc("rst", 1, 0, 0, 0, 0, 8'h00);
    chk1("rst.empty_c", empty, 1'b1);
    chk1("rst.full_c", full, 1'b0);
    chk8("rst.dout_c", data_out, 8'h00);
    for (int i = 0; i < 3; i++) cyc("idle", 0, 0, 0, 0, 0, 8'h00);

    // Packet pass-through: header 0C carries length 3 -> 4 more reads
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h3F;
    for (int i = 0; i < 5; i++) cyc("pt.wr", 0, 0, 1, 0, i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      cyc("pt.rd", 0, 0, 0, 1, 0, 8'h00);
      chk8("pt.dout_c", data_out, pkt[i]);
    end
    cyc("pt.idle", 0, 0, 0, 0, 0, 8'h00);
    chk8("pt.blank_c", data_out, 8'h00);

    // Fill and overflow
    for (int i = 0; i <= 16; i++) begin
      cyc("fill.wr", 0, 0, 1, 0, 0, 8'(i));
      if (i == 15) chk1("fill.full16_c", full, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      cyc("fill.rd", 0, 0, 0, 1, 0, 8'h00);
      chk8("fill.dout_c", data_out, 8'(i));
    end
    chk1("fill.empty_c", empty, 1'b1);

    // Wrap-around: 40 write/read pairs cross both pointer MSB wraps
    for (int i = 0; i < 40; i++) begin
      cyc("wrap.wr", 0, 0, 1, 0, 0, 8'(8'h40 + i));
      cyc("wrap.rd", 0, 0, 0, 1, 0, 8'h00);
      chk8("wrap.dout_c", data_out, 8'(8'h40 + i));
    end

    // Simultaneous read+write while full: write of AA is dropped
    for (int i = 0; i < 16; i++) cyc("sf.wr", 0, 0, 1, 0, 0, 8'($urandom_range(0, 8'h7F)));
    cyc("sf.rw", 0, 0, 1, 1, 0, 8'hAA);
    chk1("sf.full_c", full, 1'b0);
    for (int i = 0; i < 15; i++) cyc("sf.rd", 0, 0, 0, 1, 0, 8'h00);
    chk1("sf.empty_c", empty, 1'b1);

    // Simultaneous read+write while empty: write lands, read ignored
    cyc("se.rw", 0, 0, 1, 1, 0, 8'h55);
    chk1("se.empty_c", empty, 1'b0);
    cyc("se.rd", 0, 0, 0, 1, 0, 8'h00);
    chk8("se.dout_c", data_out, 8'h55);

    // Soft reset after 3 of 5 bytes written
    cyc("sr.wr", 0, 0, 1, 0, 1, 8'h0C);
    cyc("sr.wr", 0, 0, 1, 0, 0, 8'h01);
    cyc("sr.wr", 0, 0, 1, 0, 0, 8'h02);
    cyc("sr.pulse", 0, 1, 0, 0, 0, 8'h00);
    chk1("sr.empty_c", empty, 1'b1);
    // Soft reset mid-read: counter cleared so data_out blanks at once
    for (int i = 0; i < 5; i++) cyc("sr2.wr", 0, 0, 1, 0, i == 0, pkt[i]);
    cyc("sr2.rd", 0, 0, 0, 1, 0, 8'h00);
    cyc("sr2.rd", 0, 0, 0, 1, 0, 8'h00);
    cyc("sr2.pulse", 0, 1, 0, 0, 0, 8'h00);
    cyc("sr2.idle", 0, 0, 0, 0, 0, 8'h00);
    chk8("sr2.blank_c", data_out, 8'h00);
    // New packet: header 08 -> length 2
    pkt[0] = 8'h08; pkt[1] = 8'hA1; pkt[2] = 8'hB2; pkt[3] = 8'h13;
    for (int i = 0; i < 4; i++) cyc("sr3.wr", 0, 0, 1, 0, i == 0, pkt[i]);
    for (int i = 0; i < 4; i++) begin
      cyc("sr3.rd", 0, 0, 0, 1, 0, 8'h00);
      chk8("sr3.dout_c", data_out, pkt[i]);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", 0, ($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
